// File: rtl/cpu_sequencer.sv
// Phase sequencer and control decoder for the 8-bit accumulator CPU.
// Eight phases per instruction; HLT freezes the sequencer at OP_ADDR until resume.
module cpu_sequencer #(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    // state      | meaning
    // INST_ADDR  | PC drives address bus
    // INST_FETCH | instruction read from memory
    // INST_LOAD  | instruction captured into IR
    // IDLE       | IR load held while bus settles
    // OP_ADDR    | PC advanced; HLT detected here
    // OP_FETCH   | operand read for ALU ops
    // ALU_OP     | ALU operates; SKZ/JMP/STO act
    // STORE      | result written to AC, memory or PC
    // halted     | frozen at OP_ADDR until resume
    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    localparam logic [2:0] OPC_HLT = 3'd0;
    localparam logic [2:0] OPC_SKZ = 3'd1;
    localparam logic [2:0] OPC_ADD = 3'd2;
    localparam logic [2:0] OPC_AND = 3'd3;
    localparam logic [2:0] OPC_XOR = 3'd4;
    localparam logic [2:0] OPC_LDA = 3'd5;
    localparam logic [2:0] OPC_STO = 3'd6;
    localparam logic [2:0] OPC_JMP = 3'd7;

    logic [2:0] phase_q, phase_d;
    logic       halted_q, halted_d;
    logic       alu_op;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            // PC already advanced at OP_ADDR, so resume skips straight to OP_FETCH
            if (resume) begin
                halted_d = 1'b0;
                phase_d  = OP_FETCH;
            end
        end else if (HALT_STICKY && phase_q == OP_ADDR && opcode == OPC_HLT) begin
            halted_d = 1'b1;
        end else begin
            phase_d = phase_q + 3'd1;
        end
    end

    assign alu_op = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                    (opcode == OPC_XOR) || (opcode == OPC_LDA);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OPC_HLT);
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (opcode == OPC_SKZ) && zero;
                    ld_pc  = (opcode == OPC_JMP);
                    data_e = (opcode == OPC_STO);
                end
                STORE: begin
                    // JMP raises both; the PC gives its load priority over enable
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (opcode == OPC_JMP);
                    inc_pc = (opcode == OPC_JMP);
                    wr     = (opcode == OPC_STO);
                    data_e = (opcode == OPC_STO);
                end
                default: ;
            endcase
        end
    end

    assign phase = phase_q;

endmodule
